// File: rtl/pio_pkg.sv
// Shared definitions for the PIO edge-capture block: bus width and register offsets.
package pio_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic [ADDR_W-1:0] {
        REG_DATA_IN  = 3'd0,
        REG_DATA_OUT = 3'd1,
        REG_OUT_SET  = 3'd2,
        REG_OUT_CLR  = 3'd3,
        REG_IRQ_MASK = 3'd4,
        REG_EDGE_CAP = 3'd5,
        REG_RISE_EN  = 3'd6,
        REG_FALL_EN  = 3'd7
    } pio_reg_e;

endpackage

// File: rtl/pio_in_filter.sv
// Input path: 2-flop synchroniser, optional tick prescaler and two-tick agreement filter.
module pio_in_filter #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEBOUNCE_DIV = 0
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] filt,
    output logic [WIDTH-1:0] filt_nxt_c
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pin;
            s2 <= s1;
        end
    end

    generate
        if (DEBOUNCE_DIV == 0) begin : g_bypass
            assign filt_nxt_c = s2;
        end else begin : g_debounce
            localparam int unsigned PRE_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

            logic [PRE_W-1:0] pre;
            logic [WIDTH-1:0] samp;
            logic [WIDTH-1:0] agree_c;
            logic             tick_c;

            assign tick_c  = (pre == PRE_W'(DEBOUNCE_DIV - 1));
            assign agree_c = ~(s2 ^ samp);

            always_ff @(posedge clk_clk or posedge reset_reset) begin
                if (reset_reset) begin
                    pre  <= '0;
                    samp <= '0;
                end else begin
                    pre <= tick_c ? '0 : pre + PRE_W'(1);
                    if (tick_c) begin
                        samp <= s2;
                    end
                end
            end

            // a bit only follows s2 when the last two tick samples agree
            assign filt_nxt_c = tick_c ? ((filt & ~agree_c) | (s2 & agree_c)) : filt;
        end
    endgenerate

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            filt <= '0;
        end else begin
            filt <= filt_nxt_c;
        end
    end

endmodule

// File: rtl/pio_edge_capture.sv
// PIO with output set/clear, filtered inputs, per-bit edge capture and masked level interrupt.
module pio_edge_capture
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEBOUNCE_DIV = 0
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    output logic [BUS_W-1:0]  avs_readdata,
    input  logic              avs_write,
    input  logic [BUS_W-1:0]  avs_writedata,
    input  logic [WIDTH-1:0]  pio_in_export,
    output logic [WIDTH-1:0]  pio_out_export,
    output logic              irq
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_nxt_c;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] wdata_c;
    logic [WIDTH-1:0] w1c_c;
    logic [WIDTH-1:0] new_edge_c;
    logic [BUS_W-1:0] rd_c;

    pio_in_filter #(
        .WIDTH        (WIDTH),
        .DEBOUNCE_DIV (DEBOUNCE_DIV)
    ) u_in_filter (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .pin         (pio_in_export),
        .filt        (filt),
        .filt_nxt_c  (filt_nxt_c)
    );

    generate
        if (WIDTH < BUS_W) begin : g_wdata_upper
            logic unused_wdata;
            assign unused_wdata = ^avs_writedata[BUS_W-1:WIDTH];
        end
    endgenerate

    assign wdata_c        = avs_writedata[WIDTH-1:0];
    assign pio_out_export = data_out;

    // edges are detected against the value filt is about to load, so capture lands on the same edge
    assign new_edge_c = (filt_nxt_c & ~filt & rise_en) | (~filt_nxt_c & filt & fall_en);
    assign w1c_c      = (avs_write && (avs_address == REG_EDGE_CAP)) ? wdata_c : '0;

    always_comb begin
        rd_c = '0;
        case (avs_address)
            REG_DATA_IN:  rd_c = BUS_W'(filt);
            REG_DATA_OUT: rd_c = BUS_W'(data_out);
            REG_IRQ_MASK: rd_c = BUS_W'(irq_mask);
            REG_EDGE_CAP: rd_c = BUS_W'(edge_cap);
            REG_RISE_EN:  rd_c = BUS_W'(rise_en);
            REG_FALL_EN:  rd_c = BUS_W'(fall_en);
            default:      rd_c = '0;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            data_out <= '0;
            irq_mask <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
        end else if (avs_write) begin
            case (avs_address)
                REG_DATA_OUT: data_out <= wdata_c;
                REG_OUT_SET:  data_out <= data_out | wdata_c;
                REG_OUT_CLR:  data_out <= data_out & ~wdata_c;
                REG_IRQ_MASK: irq_mask <= wdata_c;
                REG_RISE_EN:  rise_en  <= wdata_c;
                REG_FALL_EN:  fall_en  <= wdata_c;
                default:      ;
            endcase
        end
    end

    // a new edge overrides a same-cycle write-1-to-clear
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            edge_cap     <= '0;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            edge_cap <= (edge_cap & ~w1c_c) | new_edge_c;
            irq      <= |(edge_cap & irq_mask);
            if (avs_read) begin
                avs_readdata <= rd_c;
            end
        end
    end

endmodule

// File: tb/tb_pio_edge_capture.sv
// Bench for pio_edge_capture: bypass and debounced instances on a shared bus against a cycle model.
module tb_pio_edge_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  pin;

    logic [31:0] rdata0, rdata4;
    logic [7:0]  pout0, pout4;
    logic        irq0, irq4;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pio_edge_capture #(.WIDTH(8), .DEBOUNCE_DIV(0)) dut0 (
        .clk_clk        (clk),
        .reset_reset    (rst),
        .avs_address    (addr),
        .avs_read       (rd),
        .avs_readdata   (rdata0),
        .avs_write      (wr),
        .avs_writedata  (wdata),
        .pio_in_export  (pin),
        .pio_out_export (pout0),
        .irq            (irq0)
    );

    pio_edge_capture #(.WIDTH(8), .DEBOUNCE_DIV(4)) dut4 (
        .clk_clk        (clk),
        .reset_reset    (rst),
        .avs_address    (addr),
        .avs_read       (rd),
        .avs_readdata   (rdata4),
        .avs_write      (wr),
        .avs_writedata  (wdata),
        .pio_in_export  (pin),
        .pio_out_export (pout4),
        .irq            (irq4)
    );

    // Reference model: index 0 = bypass, index 1 = tick every 4 clocks
    int          div_of [2] = '{0, 4};
    logic [7:0]  m_out  [2];
    logic [7:0]  m_mask [2];
    logic [7:0]  m_cap  [2];
    logic [7:0]  m_rise [2];
    logic [7:0]  m_fall [2];
    logic [7:0]  m_filt [2];
    logic [7:0]  m_samp [2];
    logic        m_irq  [2];
    logic [31:0] m_rdata[2];
    logic [7:0]  hist[$];

    function automatic logic [7:0] reg_val(int k, logic [2:0] a);
        case (a)
            3'd0: return m_filt[k];
            3'd1: return m_out[k];
            3'd4: return m_mask[k];
            3'd5: return m_cap[k];
            3'd6: return m_rise[k];
            3'd7: return m_fall[k];
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_edge(int k);
        int         edges;
        int         dv;
        logic [7:0] s2;
        logic [7:0] nf;
        logic [7:0] agree;
        logic [7:0] w1c;
        logic [7:0] wd;
        edges = hist.size();
        dv    = div_of[k];
        s2    = (edges >= 2) ? hist[edges-2] : 8'h00;
        nf    = m_filt[k];
        wd    = wdata[7:0];
        if (dv == 0) begin
            nf = s2;
        end else if ((edges % dv) == dv - 1) begin
            agree     = ~(s2 ^ m_samp[k]);
            nf        = (m_filt[k] & ~agree) | (s2 & agree);
            m_samp[k] = s2;
        end
        if (rd) m_rdata[k] = {24'h0, reg_val(k, addr)};
        m_irq[k] = |(m_cap[k] & m_mask[k]);
        w1c      = (wr && addr == 3'd5) ? wd : 8'h00;
        m_cap[k] = (m_cap[k] & ~w1c) | (nf & ~m_filt[k] & m_rise[k]) | (~nf & m_filt[k] & m_fall[k]);
        if (wr) begin
            case (addr)
                3'd1: m_out[k]  = wd;
                3'd2: m_out[k]  = m_out[k] | wd;
                3'd3: m_out[k]  = m_out[k] & ~wd;
                3'd4: m_mask[k] = wd;
                3'd6: m_rise[k] = wd;
                3'd7: m_fall[k] = wd;
                default: ;
            endcase
        end
        m_filt[k] = nf;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_out[k] = 8'h00; m_mask[k] = 8'h00; m_cap[k] = 8'h00;
                m_rise[k] = 8'h00; m_fall[k] = 8'h00; m_filt[k] = 8'h00;
                m_samp[k] = 8'h00; m_irq[k] = 1'b0; m_rdata[k] = 32'h0;
            end
            hist.delete();
        end else begin
            for (int k = 0; k < 2; k++) model_edge(k);
            hist.push_back(pin);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pout0", {24'h0, pout0}, {24'h0, m_out[0]});
        chk("pout4", {24'h0, pout4}, {24'h0, m_out[1]});
        chk("irq0", {31'h0, irq0}, {31'h0, m_irq[0]});
        chk("irq4", {31'h0, irq4}, {31'h0, m_irq[1]});
        chk("rdata0", rdata0, m_rdata[0]);
        chk("rdata4", rdata4, m_rdata[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a);
        addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        int idx;
        rd = 1'b0; wr = 1'b0; addr = 3'd0; wdata = 32'h0; pin = 8'h00;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_irq0", {31'h0, irq0}, 32'h0);
        chk("rst_pout0", {24'h0, pout0}, 32'h0);
        rst = 1'b0;

        // all registers read zero out of reset
        for (int a = 0; a < 8; a++) begin
            rd_reg(3'(a));
            chk("rst_read0", rdata0, 32'h0);
            chk("rst_read4", rdata4, 32'h0);
        end

        // output write / set / clear
        wr_reg(3'd1, 32'hFFFF_FFA5);
        chk("out_write", {24'h0, pout0}, 32'hA5);
        wr_reg(3'd2, 32'h0F);
        chk("out_set", {24'h0, pout0}, 32'hAF);
        wr_reg(3'd3, 32'h81);
        chk("out_clr", {24'h0, pout0}, 32'h2E);
        rd_reg(3'd1);
        chk("rd_data_out", rdata0, 32'h2E);
        rd_reg(3'd2);
        chk("rd_out_set_wo", rdata0, 32'h0);
        wr_reg(3'd0, 32'hFF);
        rd_reg(3'd0);
        chk("data_in_ro", rdata0, 32'h0);

        // bypass rising edge latency and interrupt
        wr_reg(3'd6, 32'h01);
        wr_reg(3'd4, 32'h01);
        pin = 8'h01;
        tick(); tick(); tick();
        chk("irq_not_yet", {31'h0, irq0}, 32'h0);
        addr = 3'd0; rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("data_in_k2", rdata0, 32'h01);
        chk("irq_k3", {31'h0, irq0}, 32'h1);
        rd_reg(3'd5);
        chk("edge_cap_set", rdata0, 32'h01);
        wr_reg(3'd5, 32'h01);
        chk("irq_hold_after_w1c", {31'h0, irq0}, 32'h1);
        tick();
        chk("irq_clear", {31'h0, irq0}, 32'h0);

        // debounced glitch rejection then acceptance on bit3
        repeat (16) tick();
        wr_reg(3'd6, 32'h09);
        wr_reg(3'd5, 32'hFF);
        pin = 8'h09;
        repeat (4) tick();
        pin = 8'h01;
        repeat (12) tick();
        rd_reg(3'd0);
        chk("glitch_data_in4", rdata4, 32'h01);
        rd_reg(3'd5);
        chk("glitch_cap4", rdata4, 32'h00);
        pin = 8'h09;
        repeat (16) tick();
        rd_reg(3'd0);
        chk("held_data_in4", rdata4, 32'h09);
        rd_reg(3'd5);
        chk("held_cap4", rdata4, 32'h08);

        // W1C coinciding with a new rising edge on bit0
        wr_reg(3'd7, 32'h01);
        pin = 8'h08;
        repeat (16) tick();
        rd_reg(3'd5);
        chk("cap_before_w1c", {31'h0, rdata0[0]}, 32'h1);
        pin = 8'h09;
        tick(); tick();
        addr = 3'd5; wdata = 32'h01; wr = 1'b1;
        tick();
        wr = 1'b0;
        rd_reg(3'd5);
        chk("edge_wins_w1c", {31'h0, rdata0[0]}, 32'h1);

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            rd    = 1'($urandom % 2);
            wr    = ($urandom % 4) == 0;
            addr  = 3'($urandom % 8);
            wdata = $urandom;
            if (($urandom % 8) == 0) begin
                idx = int'($urandom % 8);
                pin[idx] = ~pin[idx];
            end
            tick();
        end
        rd = 1'b0; wr = 1'b0;

        // fill captures, then reset mid-cycle
        wr_reg(3'd6, 32'hFF);
        wr_reg(3'd7, 32'hFF);
        wr_reg(3'd4, 32'hFF);
        for (int t = 0; t < 3; t++) begin
            pin = ~pin;
            repeat (20) tick();
        end
        rd_reg(3'd5);
        chk("cap_full0", rdata0, 32'hFF);
        chk("irq_before_rst", {31'h0, irq0}, 32'h1);
        pin = 8'h5A;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_irq0", {31'h0, irq0}, 32'h0);
        chk("async_irq4", {31'h0, irq4}, 32'h0);
        chk("async_pout0", {24'h0, pout0}, 32'h0);
        chk("async_rdata0", rdata0, 32'h0);
        chk("async_rdata4", rdata4, 32'h0);
        @(negedge clk);
        pin = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd_reg(3'(a));
            chk("post_rst0", rdata0, 32'h0);
            chk("post_rst4", rdata4, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_edge_capture.md
PIO_EDGE_CAPTURE -- requirements
Module: pio_edge_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 32, number of PIO bits (legal 1..32).
REQ-002 SHALL have parameter DEBOUNCE_DIV, default 0, sample-tick period in clocks (0 = filter bypass).
REQ-003 SHALL have port clk_clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_reset, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port avs_address, input, 3 bits: word register index.
REQ-006 SHALL have port avs_read, input, 1 bit: read strobe.
REQ-007 SHALL have port avs_readdata, output, 32 bits: read data; fixed read latency 1; no waitrequest.
REQ-008 SHALL have port avs_write, input, 1 bit: write strobe, single-cycle accept.
REQ-009 SHALL have port avs_writedata, input, 32 bits: write data.
REQ-010 SHALL have port pio_in_export, input, WIDTH bits: asynchronous external inputs.
REQ-011 SHALL have port pio_out_export, output, WIDTH bits: registered outputs.
REQ-012 SHALL have port irq, output, 1 bit: registered level interrupt.

Function
REQ-013 Register map SHALL be: 0 DATA_IN (RO, filtered input); 1 DATA_OUT (RW); 2 OUT_SET (WO, bitwise OR); 3 OUT_CLR (WO, bitwise AND-NOT); 4 IRQ_MASK (RW); 5 EDGE_CAP (R, W1C); 6 RISE_EN (RW); 7 FALL_EN (RW).
REQ-014 Read data bits [31:WIDTH] SHALL be 0; WO registers SHALL read 0; writes to DATA_IN SHALL be ignored.
REQ-015 avs_readdata SHALL be registered: valid the clock after avs_read high, held until next read; avs_read and avs_write together -> write performed, read data still returned (pre-write value).
REQ-016 pio_out_export SHALL equal DATA_OUT; a write to 1/2/3 SHALL appear on pins the following clock.
REQ-017 pio_in_export SHALL pass a 2-flop synchroniser (s1, s2) before any use.
REQ-018 DEBOUNCE_DIV=0: filtered register SHALL load s2 every clock; pin change at edge k visible in DATA_IN at edge k+2.
REQ-019 DEBOUNCE_DIV=N>0: prescaler SHALL count 0..N-1 and wrap, tick on N-1; on tick, per bit, filtered SHALL load s2 only if s2 equals the previous tick's sample; change thus needs 2 consecutive agreeing ticks.
REQ-020 EDGE_CAP[i] SHALL set on the same edge filtered[i] changes 0->1 with RISE_EN[i]=1, or 1->0 with FALL_EN[i]=1.
REQ-021 Writing 1 to EDGE_CAP[i] SHALL clear it; same-cycle new edge on bit i SHALL win (bit stays set).
REQ-022 irq SHALL be registered |(EDGE_CAP & IRQ_MASK), asserting one clock after the capture bit sets and deasserting one clock after clear/mask.
REQ-023 Register writes SHALL mask to WIDTH bits; prescaler width SHALL be clog2(DEBOUNCE_DIV) min 1.

Reset
REQ-024 On reset_reset high, all registers (DATA_OUT, IRQ_MASK, EDGE_CAP, RISE_EN, FALL_EN, s1, s2, filtered, tick sample, prescaler, avs_readdata, irq) SHALL clear to 0 asynchronously.
REQ-025 Reset mid-debounce or mid-read SHALL discard state; no edge SHALL be captured from the 0-reset filtered value until an actual post-reset transition through the filter.
REQ-026 Release SHALL be synchronous to clk_clk (external synchroniser assumed absent here: release deassertion is the integrator's duty).

Structure
REQ-027 Register offsets and the 32-bit bus width SHALL live in shared package pio_pkg.
REQ-028 Input path (synchroniser + prescaler + filter) SHALL be one sub-module pio_in_filter; edge/capture/bus logic in top.

Verification
REQ-029 Reset, WIDTH=8: all reads return 0x00000000, pio_out_export=0x00, irq=0.
REQ-030 Write DATA_OUT=0xA5, OUT_SET=0x0F, OUT_CLR=0x81 -> pins 0xA5, 0xAF, 0x2E, each one clock after write; read DATA_OUT=0x2E.
REQ-031 DIV=0, RISE_EN=0x01, IRQ_MASK=0x01, pin0 0->1 at edge k -> DATA_IN bit0 at k+2, EDGE_CAP=0x01 at k+2, irq at k+3; W1C 0x01 -> irq low 2 clocks after write.
REQ-032 DIV=4: 1-tick glitch on pin3 -> DATA_IN unchanged, EDGE_CAP=0; level held 3 ticks -> DATA_IN bit3 set.
REQ-033 W1C to bit0 in same cycle as new rising edge on bit0 -> EDGE_CAP bit0 remains 1.
REQ-034 Assert reset_reset mid-debounce with EDGE_CAP=0xFF -> all registers 0 immediately, irq 0 without clock.
